vectored_int_ctrl: RTL and testbench
====================================

Name: vectored_int_ctrl

Overview:
- Parametrised successor to the fixed 4-input HVPI interrupt block: N-channel, prioritised, vectored interrupt controller with nesting.
- Sits between external interrupt lines and the sequencing controller.
- Per-channel edge/level detection, mask register, global enable, pending and in-service tracking.
- Supplies a registered ISR vector for the PC input mux.

Parameters:
NUM_INTS, 8, number of interrupt channels (2..32); channel 0 has the highest priority
PC_WIDTH, 8, width of isrAddr
ISR_BASE, 8'h80, vector address of channel 0
ISR_STRIDE, 4, address distance between consecutive channel vectors
EDGE_MODE, all ones (NUM_INTS bits), per channel: 1 = rising-edge triggered, 0 = level triggered

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ints  in  NUM_INTS  raw interrupt request lines, synchronous to clk
intMask  in  NUM_INTS  mask load data; 1 = channel enabled
ldMask  in  1  load intMask into the mask register
clrMask  in  1  clear the mask register
intEnable  in  1  set the global enable
intDisable  in  1  clear the global enable
intAck  in  1  one-cycle pulse: controller accepts the presented interrupt
intDone  in  1  one-cycle pulse: return from ISR
isrAddr  out  PC_WIDTH  vector of the presented interrupt
intId  out  $clog2(NUM_INTS)  channel number of the presented interrupt
intPending  out  1  an interrupt is presented
inService  out  NUM_INTS  in-service bits

Behaviour:
Reset (reset=0, asynchronous):
- ints_q, pending, mask, inService, global enable, intPending, intId and isrAddr all go to 0.
- Reset asserted mid-ISR drops all nesting state.

Detection (every clk edge, ints_q <= ints):
- Edge channel: the pending bit is set when ints & ~ints_q.
- Level channel: the pending bit is loaded with ints_q each cycle and is not latched.

Mask:
- clrMask has priority over ldMask.
- The mask does not affect pending bits. It gates presentation only; masked edges stay pending.

Global enable:
- intDisable has priority over intEnable.

Eligibility:
- elig = pending & mask & enable & ~inService.
- Channel i is eligible only if i < the lowest set inService index; if inService = 0, every channel qualifies.
- The winner is the lowest eligible index.

Outputs (registered; one cycle after the pending/mask/inService state settles):
- intPending = |elig.
- intId = winner.
- isrAddr = ISR_BASE + winner*ISR_STRIDE, truncated to PC_WIDTH.
- When intPending=0, intId and isrAddr hold their last value.
- Latency: ints rises before edge N, pending is set at N, intPending is high after N+1.

Handshake:
- intAck while intPending=1:
  - sets inService[intId];
  - clears pending[intId] (edge channels only);
  - deasserts intPending at the same edge.
- The next candidate is presented at the following edge at the earliest.
- intAck while intPending=0 is ignored.

Completion:
- intDone clears the lowest set inService bit.
- intDone with inService = 0 is ignored.

Simultaneous events:
- intDone and intAck in the same cycle: intDone clears first, then intAck sets.
- intAck and a new edge on the same channel in the same cycle: the edge wins, and the pending bit stays set.
- A level channel stays pending while its line is high. Software must clear the source before intDone, or the interrupt re-enters.

Nesting:
- Depth is bounded only by NUM_INTS, since each channel can be in service at most once.

Test Plan:
- Reset: hold reset=0 with ints=8'hFF, then release with enable=0 -> all outputs stay 0; pending = 8'hFF on the edge channels.
- Vector and latency: mask=8'hFF, enable, pulse ints[3] -> intPending=1 two edges later, intId=3, isrAddr=8'h8C; intAck -> intPending=0, inService=8'h08.
- Priority and nesting: inService[3] set, raise ints[5] and ints[1] -> intId=1 presented, ch5 withheld; ack, intDone, intDone -> ch5 presented, isrAddr=8'h94.
- Masking: clrMask, pulse ints[2] -> intPending stays 0; ldMask with 8'h04 -> intPending=1, intId=2. ldMask and clrMask together -> mask=0.
- Level mode (EDGE_MODE[0]=0): hold ints[0]=1 -> ack, intDone -> re-presented; drop ints[0] before intDone -> no re-entry.
- Simultaneous events: intAck in the same cycle as a new ints[4] edge on presented ch4 -> pending[4] stays 1. intDone with intAck -> inService shows only the new bit. intAck with intPending=0 -> no change.

Source files
------------

// File: rtl/vectored_int_ctrl.sv
// rtl/vectored_int_ctrl.sv - N-channel prioritised, vectored, nesting interrupt controller
module vectored_int_ctrl #(
  parameter int unsigned         NUM_INTS   = 8,
  parameter int unsigned         PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] ISR_BASE   = 8'h80,
  parameter int unsigned         ISR_STRIDE = 4,
  parameter logic [NUM_INTS-1:0] EDGE_MODE  = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INTS-1:0]         ints,
  input  logic [NUM_INTS-1:0]         intMask,
  input  logic                        ldMask,
  input  logic                        clrMask,
  input  logic                        intEnable,
  input  logic                        intDisable,
  input  logic                        intAck,
  input  logic                        intDone,
  output logic [PC_WIDTH-1:0]         isrAddr,
  output logic [$clog2(NUM_INTS)-1:0] intId,
  output logic                        intPending,
  output logic [NUM_INTS-1:0]         inService
);
  localparam int unsigned ID_W = $clog2(NUM_INTS);
  localparam logic [NUM_INTS-1:0] ONE = NUM_INTS'(1);

  logic [NUM_INTS-1:0] r_ints_q, r_pending, r_mask, r_in_service;
  logic                r_enable, r_int_pending;
  logic [ID_W-1:0]     r_int_id;
  logic [PC_WIDTH-1:0] r_isr_addr;

  logic                w_ack, w_found, w_blocked;
  logic [NUM_INTS-1:0] w_ack_bit, w_pending_nxt, w_in_service_nxt, w_elig;
  logic [ID_W-1:0]     w_winner;
  logic [PC_WIDTH-1:0] w_addr;

  always_comb begin
    w_ack     = intAck & r_int_pending;
    w_ack_bit = w_ack ? (ONE << r_int_id) : '0;
    // Completion retires the lowest set bit before a same-cycle accept adds its own.
    w_in_service_nxt = (intDone ? (r_in_service & (r_in_service - ONE)) : r_in_service) | w_ack_bit;
    // A fresh edge on the acknowledged channel re-arms it rather than being lost.
    w_pending_nxt = (((r_pending & ~w_ack_bit) | (ints & ~r_ints_q)) & EDGE_MODE)
                  | (r_ints_q & ~EDGE_MODE);

    // Only channels strictly above (numerically below) the innermost active ISR may nest.
    w_blocked = 1'b0;
    w_elig    = '0;
    for (int i = 0; i < int'(NUM_INTS); i++) begin
      w_blocked = w_blocked | r_in_service[i];
      w_elig[i] = r_pending[i] & r_mask[i] & r_enable & ~w_blocked;
    end

    w_winner = '0;
    for (int i = int'(NUM_INTS) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = ID_W'(i);
    end
    w_found = |w_elig;
    w_addr  = PC_WIDTH'(32'(ISR_BASE) + 32'(w_winner) * ISR_STRIDE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ints_q      <= '0;
      r_pending     <= '0;
      r_mask        <= '0;
      r_in_service  <= '0;
      r_enable      <= 1'b0;
      r_int_pending <= 1'b0;
      r_int_id      <= '0;
      r_isr_addr    <= '0;
    end else begin
      r_ints_q     <= ints;
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
      if (clrMask)      r_mask <= '0;
      else if (ldMask)  r_mask <= intMask;
      if (intDisable)     r_enable <= 1'b0;
      else if (intEnable) r_enable <= 1'b1;
      if (w_ack) begin
        r_int_pending <= 1'b0;
      end else begin
        r_int_pending <= w_found;
        if (w_found) begin
          r_int_id   <= w_winner;
          r_isr_addr <= w_addr;
        end
      end
    end
  end

  assign isrAddr    = r_isr_addr;
  assign intId      = r_int_id;
  assign intPending = r_int_pending;
  assign inService  = r_in_service;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb/tb_vectored_int_ctrl.sv - self-checking bench for vectored_int_ctrl
module tb_vectored_int_ctrl;
  localparam int N = 8;
  localparam logic [7:0] EDGE = 8'hFE;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ints = '0, intMask = '0;
  logic       ldMask = 1'b0, clrMask = 1'b0, intEnable = 1'b0, intDisable = 1'b0;
  logic       intAck = 1'b0, intDone = 1'b0;
  logic [7:0] isrAddr;
  logic [2:0] intId;
  logic       intPending;
  logic [7:0] inService;

  int checks = 0;
  int errors = 0;

  vectored_int_ctrl #(
    .NUM_INTS(8), .PC_WIDTH(8), .ISR_BASE(8'h80), .ISR_STRIDE(4), .EDGE_MODE(EDGE)
  ) dut (
    .clk(clk), .reset(reset), .ints(ints), .intMask(intMask), .ldMask(ldMask),
    .clrMask(clrMask), .intEnable(intEnable), .intDisable(intDisable),
    .intAck(intAck), .intDone(intDone), .isrAddr(isrAddr), .intId(intId),
    .intPending(intPending), .inService(inService)
  );

  always #5 clk = ~clk;

  // Model: per-channel flags plus a stack of active ISRs (innermost at the back).
  bit m_q[N], m_pend[N], m_mask[N];
  bit m_en, m_ip;
  int m_stack[$];
  int m_id, m_addr;

  function automatic logic [7:0] m_is();
    logic [7:0] v = '0;
    foreach (m_stack[k]) v[m_stack[k]] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_q[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
      end
      m_en = 0; m_ip = 0; m_id = 0; m_addr = 0;
      m_stack.delete();
    end else begin
      bit ack;
      int win, limit, old_id;
      ack    = intAck && m_ip;
      old_id = m_id;
      limit  = (m_stack.size() > 0) ? m_stack[$] : N;
      win    = -1;
      for (int i = 0; i < limit; i++)
        if (win < 0 && m_pend[i] && m_mask[i] && m_en) win = i;
      if (ack) m_ip = 0;
      else begin
        m_ip = (win >= 0);
        if (win >= 0) begin
          m_id   = win;
          m_addr = (128 + win * 4) % 256;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (EDGE[i]) begin
          if (ack && i == old_id) m_pend[i] = 0;
          if (ints[i] && !m_q[i]) m_pend[i] = 1;
        end else begin
          m_pend[i] = m_q[i];
        end
      end
      if (intDone && m_stack.size() > 0) void'(m_stack.pop_back());
      if (ack) m_stack.push_back(old_id);
      for (int i = 0; i < N; i++) begin
        if (clrMask)     m_mask[i] = 0;
        else if (ldMask) m_mask[i] = intMask[i];
      end
      if (intDisable)     m_en = 0;
      else if (intEnable) m_en = 1;
      for (int i = 0; i < N; i++) m_q[i] = ints[i];
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cmp("intPending", 32'(intPending), 32'(m_ip));
      cmp("intId", 32'(intId), 32'(m_id));
      cmp("isrAddr", 32'(isrAddr), 32'(m_addr));
      cmp("inService", 32'(inService), 32'(m_is()));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with all lines high, release with everything disabled
    ints = 8'hFF; step(3);
    reset = 1'b1; step(4);
    cmp("rst_pending", 32'(intPending), 0);
    cmp("rst_inService", 32'(inService), 0);
    cmp("rst_isrAddr", 32'(isrAddr), 0);
    cmp("rst_intId", 32'(intId), 0);
    reset = 1'b0; ints = '0; step(2); reset = 1'b1; step(2);

    // Vector and latency
    ldMask = 1; intMask = 8'hFF; intEnable = 1; step(1); ldMask = 0; intEnable = 0;
    ints = 8'h08; step(1); ints = 0;
    cmp("lat_early", 32'(intPending), 0);
    step(1);
    cmp("vec_pending", 32'(intPending), 1);
    cmp("vec_id", 32'(intId), 3);
    cmp("vec_addr", 32'(isrAddr), 32'h8C);
    cmp("model_addr", 32'(m_addr), 32'h8C);
    intAck = 1; step(1); intAck = 0;
    cmp("ack_pending", 32'(intPending), 0);
    cmp("ack_is", 32'(inService), 32'h08);

    // Priority and nesting
    ints = 8'h22; step(1); ints = 0; step(1);
    cmp("prio_pending", 32'(intPending), 1);
    cmp("prio_id", 32'(intId), 1);
    cmp("prio_addr", 32'(isrAddr), 32'h84);
    intAck = 1; step(1); intAck = 0;
    cmp("nest_is", 32'(inService), 32'h0A);
    intDone = 1; step(1); intDone = 0; step(2);
    cmp("ch5_withheld", 32'(intPending), 0);
    intDone = 1; step(1); intDone = 0; step(1);
    cmp("ch5_pending", 32'(intPending), 1);
    cmp("ch5_id", 32'(intId), 5);
    cmp("ch5_addr", 32'(isrAddr), 32'h94);
    intAck = 1; step(1); intAck = 0; intDone = 1; step(1); intDone = 0; step(2);

    // Masking
    clrMask = 1; step(1); clrMask = 0;
    ints = 8'h04; step(1); ints = 0; step(3);
    cmp("masked_idle", 32'(intPending), 0);
    intMask = 8'h04; ldMask = 1; step(1); ldMask = 0; step(1);
    cmp("mask_pending", 32'(intPending), 1);
    cmp("mask_id", 32'(intId), 2);
    intAck = 1; step(1); intAck = 0; intDone = 1; step(1); intDone = 0;
    intMask = 8'hFF; ldMask = 1; clrMask = 1; step(1); ldMask = 0; clrMask = 0;
    ints = 8'h40; step(1); ints = 0; step(3);
    cmp("clr_over_ld", 32'(intPending), 0);
    ldMask = 1; step(1); ldMask = 0; step(1);
    cmp("masked_kept_pending", 32'(intPending), 1);
    cmp("masked_kept_id", 32'(intId), 6);
    cmp("masked_kept_addr", 32'(isrAddr), 32'h98);
    intAck = 1; step(1); intAck = 0; intDone = 1; step(1); intDone = 0; step(1);

    // Level-triggered channel 0
    ints = 8'h01; step(3);
    cmp("level_pending", 32'(intPending), 1);
    cmp("level_id", 32'(intId), 0);
    cmp("level_addr", 32'(isrAddr), 32'h80);
    intAck = 1; step(1); intAck = 0;
    cmp("level_is", 32'(inService), 32'h01);
    intDone = 1; step(1); intDone = 0; step(1);
    cmp("level_reenter", 32'(intPending), 1);
    intAck = 1; step(1); intAck = 0; ints = 0; step(3);
    intDone = 1; step(1); intDone = 0; step(3);
    cmp("level_no_reenter", 32'(intPending), 0);
    cmp("level_idle_is", 32'(inService), 0);

    // Accept coinciding with a new edge on the same channel
    ints = 8'h10; step(1); ints = 0; step(1);
    cmp("sim_id", 32'(intId), 4);
    intAck = 1; ints = 8'h10; step(1); intAck = 0; ints = 0;
    cmp("sim_is", 32'(inService), 32'h10);
    step(2);
    cmp("sim_withheld", 32'(intPending), 0);
    intDone = 1; step(1); intDone = 0; step(1);
    cmp("edge_won", 32'(intPending), 1);
    cmp("edge_won_id", 32'(intId), 4);
    intAck = 1; step(1); intAck = 0; intDone = 1; step(1); intDone = 0; step(2);
    cmp("edge_consumed", 32'(intPending), 0);

    // Completion and accept in the same cycle
    ints = 8'h10; step(1); ints = 0; step(1); intAck = 1; step(1); intAck = 0;
    ints = 8'h04; step(1); ints = 0; step(1);
    cmp("nest2_id", 32'(intId), 2);
    intAck = 1; intDone = 1; step(1); intAck = 0; intDone = 0;
    cmp("done_ack_is", 32'(inService), 32'h04);
    intDone = 1; step(1); intDone = 0; step(2);

    // Stray accept with nothing presented
    intAck = 1; step(1); intAck = 0;
    cmp("stray_ack_is", 32'(inService), 0);
    cmp("stray_ack_pending", 32'(intPending), 0);

    // Reset in the middle of an ISR
    ints = 8'h80; step(1); ints = 0; step(1); intAck = 1; step(1); intAck = 0;
    cmp("pre_rst_is", 32'(inService), 32'h80);
    reset = 1'b0; #1;
    cmp("midisr_rst_is", 32'(inService), 0);
    cmp("midisr_rst_addr", 32'(isrAddr), 0);
    step(2); reset = 1'b1; step(3);
    cmp("post_rst_pending", 32'(intPending), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
